// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer: FSM states, field widths, immediate expansion.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_seq_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    localparam int INSTR_BYTES = 4;
    localparam int IMM_W       = 16;
    localparam int JIDX_W      = 26;

    // Word offset of a branch: sign-extended immediate scaled to bytes.
    function automatic logic [31:0] imm_to_offset(input logic [IMM_W-1:0] imm);
        return {{(32-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Candidate next-PC arithmetic: PC+4, branch target, jump target.
// Latency: purely combinational.
// Backpressure: none; results are consumed or ignored by the sequencer.
module pc_target_calc
    import pc_seq_pkg::*;
(
    input  logic [31:0]       pc,
    input  logic [31:0]       branch_pc4,
    input  logic [IMM_W-1:0]  branch_imm,
    input  logic [31:0]       jump_pc4,
    input  logic [JIDX_W-1:0] jump_index,
    output logic [31:0]       pc_plus4,
    output logic [31:0]       branch_target,
    output logic [31:0]       jump_target
);

    // Only the region bits of the jump's PC+4 take part in the target.
    logic unused_jpc4_lo;
    assign unused_jpc4_lo = ^jump_pc4[27:0];

    assign pc_plus4      = pc + 32'(INSTR_BYTES);
    assign branch_target = branch_pc4 + imm_to_offset(branch_imm);
    assign jump_target   = {jump_pc4[31:28], jump_index, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, next-PC arbitration (branch > jump > stall > PC+4), flush pulses, fetch bubbles; BRANCH_STATS_EN adds counters.
// Latency: redirect at edge N -> PC=target after N; target fetched with PcValid=1 after edge N+BUBBLES.
// Backpressure: Stall holds PC and freezes the bubble count; a redirect overrides Stall.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          BUBBLES  = 1,
    parameter int          STAT_W   = 32
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Stall,
    input  logic              BranchReq,
    input  logic              BranchTaken,
    input  logic [31:0]       BranchPC4,
    input  logic [IMM_W-1:0]  BranchImm,
    input  logic              JumpReq,
    input  logic [31:0]       JumpPC4,
    input  logic [JIDX_W-1:0] JumpIndex,
    output logic [31:0]       PC,
    output logic              PcValid,
    output logic              Flush,
    output logic              FlushEx,
    output logic [STAT_W-1:0] TakenCnt,
    output logic [STAT_W-1:0] JumpCnt
);

    localparam logic [1:0] BUB_INIT = 2'(BUBBLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  cnt;
    logic [1:0]  cnt_nxt;
    logic [31:0] pc_nxt;
    logic        flush_nxt;
    logic        flush_ex_nxt;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        take_br;
    logic        take_jmp;

    // A same-cycle jump is younger than the resolving branch and is discarded.
    assign take_br  = BranchReq & BranchTaken;
    assign take_jmp = JumpReq & ~take_br;

    pc_target_calc u_calc (
        .pc            (PC),
        .branch_pc4    (BranchPC4),
        .branch_imm    (BranchImm),
        .jump_pc4      (JumpPC4),
        .jump_index    (JumpIndex),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .jump_target   (jump_target)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state   <= RUN;
            cnt     <= 2'd0;
            PC      <= RESET_PC;
            Flush   <= 1'b0;
            FlushEx <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            PC      <= pc_nxt;
            Flush   <= flush_nxt;
            FlushEx <= flush_ex_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pc_nxt       = PC;
        flush_nxt    = take_br | take_jmp;
        flush_ex_nxt = take_br;
        if (take_br || take_jmp) begin
            pc_nxt    = take_br ? branch_target : jump_target;
            state_nxt = BUBBLE;
            cnt_nxt   = BUB_INIT;
        end else if (!Stall) begin
            case (state)
                RUN: pc_nxt = pc_plus4;
                // Leaving BUBBLE keeps the PC so the redirect target is the next fetch.
                BUBBLE: begin
                    if (cnt == 2'd0) state_nxt = RUN;
                    else             cnt_nxt   = cnt - 2'd1;
                end
            endcase
        end
    end

    always_comb begin
        PcValid = (state == RUN);
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            TakenCnt <= '0;
            JumpCnt  <= '0;
        end else begin
            if (take_br)  TakenCnt <= TakenCnt + STAT_W'(1);
            if (take_jmp) JumpCnt  <= JumpCnt + STAT_W'(1);
        end
    end
`else
    assign TakenCnt = '0;
    assign JumpCnt  = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations, then random traffic
// checked every cycle against an abstract fetch model (remaining-bubble count plus priority rules).
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          BUBBLES  = 2;
    localparam int          STAT_W   = 32;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              Stall = 1'b0;
    logic              BranchReq = 1'b0;
    logic              BranchTaken = 1'b0;
    logic [31:0]       BranchPC4 = '0;
    logic [15:0]       BranchImm = '0;
    logic              JumpReq = 1'b0;
    logic [31:0]       JumpPC4 = '0;
    logic [25:0]       JumpIndex = '0;
    logic [31:0]       PC;
    logic              PcValid;
    logic              Flush;
    logic              FlushEx;
    logic [STAT_W-1:0] TakenCnt;
    logic [STAT_W-1:0] JumpCnt;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    bit chk_en   = 1'b0;

    pc_sequencer #(.RESET_PC(RESET_PC), .BUBBLES(BUBBLES), .STAT_W(STAT_W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Stall(Stall),
        .BranchReq(BranchReq), .BranchTaken(BranchTaken),
        .BranchPC4(BranchPC4), .BranchImm(BranchImm),
        .JumpReq(JumpReq), .JumpPC4(JumpPC4), .JumpIndex(JumpIndex),
        .PC(PC), .PcValid(PcValid), .Flush(Flush), .FlushEx(FlushEx),
        .TakenCnt(TakenCnt), .JumpCnt(JumpCnt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: hidden = fetch cycles still to be suppressed before the held target is fetched.
    logic [31:0]       m_pc = RESET_PC;
    int                m_hidden = 0;
    bit                m_flush = 0;
    bit                m_fex = 0;
    logic [STAT_W-1:0] m_tc = '0;
    logic [STAT_W-1:0] m_jc = '0;

    always @(posedge Clk) begin
        if (!Reset_n) begin
            m_pc <= RESET_PC; m_hidden <= 0; m_flush <= 0; m_fex <= 0; m_tc <= '0; m_jc <= '0;
        end else if (BranchReq && BranchTaken) begin
            m_pc <= BranchPC4 + 32'($signed(BranchImm)) * 32'd4;
            m_hidden <= BUBBLES; m_flush <= 1; m_fex <= 1; m_tc <= m_tc + 1'b1;
        end else if (JumpReq) begin
            m_pc <= (JumpPC4 & 32'hF000_0000) | (32'(JumpIndex) * 32'd4);
            m_hidden <= BUBBLES; m_flush <= 1; m_fex <= 0; m_jc <= m_jc + 1'b1;
        end else begin
            m_flush <= 0; m_fex <= 0;
            if (!Stall) begin
                if (m_hidden > 0) m_hidden <= m_hidden - 1;
                else              m_pc <= m_pc + 32'd4;
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("pc", PC, m_pc);
            check("pcvalid", 32'(PcValid), 32'(m_hidden == 0));
            check("flush", 32'(Flush), 32'(m_flush));
            check("flushex", 32'(FlushEx), 32'(m_fex));
`ifdef BRANCH_STATS_EN
            check("takencnt", TakenCnt, m_tc);
            check("jumpcnt", JumpCnt, m_jc);
`else
            check("takencnt", TakenCnt, 32'd0);
            check("jumpcnt", JumpCnt, 32'd0);
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic idle();
        Stall = 0; BranchReq = 0; BranchTaken = 0; JumpReq = 0;
    endtask

    initial begin
        // Reset, then free-running fetch
        Reset_n = 0; idle();
        step(1);
        chk_en = 1;
        step(1);
        check("rst_pc", PC, 32'h0);
        check("rst_valid", 32'(PcValid), 32'd1);
        check("rst_flush", 32'(Flush), 32'd0);
        Reset_n = 1;
        step(1); check("seq_pc1", PC, 32'h4);
        step(1); check("seq_pc2", PC, 32'h8);
        step(1); check("seq_pc3", PC, 32'hC);

        // Backward taken branch
        BranchReq = 1; BranchTaken = 1; BranchPC4 = 32'h0000_0100; BranchImm = 16'hFFFE;
        step(1); idle();
        check("br_pc", PC, 32'h0000_00F8);
        check("br_flush", 32'(Flush), 32'd1);
        check("br_flushex", 32'(FlushEx), 32'd1);
        check("br_bubble1", 32'(PcValid), 32'd0);
        step(1);
        check("br_flush_off", 32'(Flush), 32'd0);
        check("br_bubble2", 32'(PcValid), 32'd0);
        step(1);
        check("br_fetch_valid", 32'(PcValid), 32'd1);
        check("br_fetch_pc", PC, 32'h0000_00F8);
        step(1); check("br_next_pc", PC, 32'h0000_00FC);

        // Jump
        JumpReq = 1; JumpPC4 = 32'h4000_0010; JumpIndex = 26'h000_0040;
        step(1); idle();
        check("j_pc", PC, 32'h4000_0100);
        check("j_flush", 32'(Flush), 32'd1);
        check("j_flushex", 32'(FlushEx), 32'd0);
        step(2);

        // Branch and jump together under stall: branch wins
        BranchReq = 1; BranchTaken = 1; BranchPC4 = 32'h10; BranchImm = 16'h0004;
        JumpReq = 1; JumpPC4 = 32'h8000_0000; JumpIndex = 26'h3FF_FFFF; Stall = 1;
        step(1); idle();
        check("bj_pc", PC, 32'h20);
        check("bj_flushex", 32'(FlushEx), 32'd1);
`ifdef BRANCH_STATS_EN
        check("bj_takencnt", TakenCnt, 32'd2);
        check("bj_jumpcnt", JumpCnt, 32'd1);
`else
        check("bj_takencnt", TakenCnt, 32'd0);
        check("bj_jumpcnt", JumpCnt, 32'd0);
`endif
        step(2);

        // Wrapping branch, then reset during its bubble
        BranchReq = 1; BranchTaken = 1; BranchPC4 = 32'hFFFF_FFFC; BranchImm = 16'h0001;
        step(1); idle();
        check("wrap_pc", PC, 32'h0000_0000);
        check("wrap_bubble", 32'(PcValid), 32'd0);
        Reset_n = 0;
        step(1);
        check("midrst_pc", PC, RESET_PC);
        check("midrst_valid", 32'(PcValid), 32'd1);
        check("midrst_flush", 32'(Flush), 32'd0);
        Reset_n = 1;
        step(1); check("midrst_run", PC, 32'h4);
        step(1); check("stall_start", PC, 32'h8);

        // Stall in RUN holds PC
        Stall = 1;
        for (int i = 0; i < 4; i++) begin
            step(1); check("stall_hold", PC, 32'h8);
        end
        Stall = 0;
        step(1); check("stall_release", PC, 32'hC);

        // Stall inside a bubble stretches it: 2 + 3 invalid cycles
        BranchReq = 1; BranchTaken = 1; BranchPC4 = 32'h200; BranchImm = 16'h0000;
        step(1); idle();
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            step(1); check("bstall_invalid", 32'(PcValid), 32'd0);
        end
        Stall = 0;
        step(1); check("bstall_last", 32'(PcValid), 32'd0);
        step(1); check("bstall_valid", 32'(PcValid), 32'd1);
        check("bstall_pc", PC, 32'h200);
        step(1); check("bstall_next", PC, 32'h204);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            Reset_n     = ($urandom_range(0, 99) != 0);
            Stall       = ($urandom_range(0, 3) == 0);
            BranchReq   = ($urandom_range(0, 3) == 0);
            BranchTaken = $urandom_range(0, 1) == 1;
            BranchPC4   = {$urandom} & 32'hFFFF_FFFC;
            BranchImm   = 16'($urandom);
            JumpReq     = ($urandom_range(0, 4) == 0);
            JumpPC4     = {$urandom} & 32'hFFFF_FFFC;
            JumpIndex   = 26'($urandom);
            step(1);
        end
        idle(); Reset_n = 1;
        step(2);
        chk_en = 0;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
